// File: rtl/locked_mult_key_sweep_ctrl.sv
// Partial-key sweep sequencer for an XOR-locked 8x8 multiplier.
// Candidate 0 applies the base key and candidates 1..64 each flip one key bit.
// Every candidate sees the same LFSR operand sequence. A mismatch count per
// candidate is reported over a valid/ready port.
module locked_mult_key_sweep_ctrl #(
  parameter int unsigned NVEC      = 64,
  parameter int unsigned SETTLE    = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] key_base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  op1_o,
  output logic [7:0]  op2_o,
  output logic [63:0] keyinput_o,
  input  logic [15:0] locked_prod_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [6:0]  res_idx_o,
  output logic [15:0] res_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [15:0] VEC_LAST  = 16'(NVEC - 1);
  localparam logic [3:0]  SETTLE_W  = 4'(SETTLE);
  localparam logic [6:0]  CAND_LAST = 7'd64;

  // Fibonacci LFSR, taps 16,14,13,11, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  state_t      state_r, state_s;
  logic [63:0] base_r, base_s;
  logic [6:0]  cand_r, cand_s;
  logic [15:0] vec_r, vec_s;
  logic [15:0] err_r, err_s;
  logic [15:0] lfsr_r, lfsr_s;
  logic [3:0]  wait_r, wait_s;
  logic [7:0]  op1_r, op1_s;
  logic [7:0]  op2_r, op2_s;
  logic [63:0] key_r, key_s;
  logic        busy_r, done_r, valid_r;
  logic [15:0] golden_s;
  logic [63:0] flip_s;
  logic        mismatch_s;

  // The reference product is computed from the operands actually presented.
  assign golden_s   = 16'(op1_r) * 16'(op2_r);
  assign mismatch_s = (locked_prod_i != golden_s);
  assign flip_s     = (cand_r == 7'd0) ? 64'd0 : (64'd1 << (cand_r - 7'd1));

  // Next-state and next-datapath logic; abort freezes everything except the state.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    cand_s  = cand_r;
    vec_s   = vec_r;
    err_s   = err_r;
    lfsr_s  = lfsr_r;
    wait_s  = wait_r;
    op1_s   = op1_r;
    op2_s   = op2_r;
    key_s   = key_r;
    if (abort_i && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            base_s  = key_base_i;
            cand_s  = 7'd0;
            vec_s   = 16'd0;
            err_s   = 16'd0;
            lfsr_s  = LFSR_SEED;
            state_s = ST_DRIVE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          op1_s  = lfsr_r[15:8];
          op2_s  = lfsr_r[7:0];
          key_s  = base_r ^ flip_s;
          wait_s = 4'd0;
          if (SETTLE_W != 4'd0) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_CHECK;
          end
        end
        ST_WAIT: begin
          if (wait_r == (SETTLE_W - 4'd1)) begin
            state_s = ST_CHECK;
          end else begin
            wait_s = wait_r + 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch_s) begin
            err_s = err_r + 16'd1;
          end else begin
            err_s = err_r;
          end
          lfsr_s = lfsr_step(lfsr_r);
          if (vec_r == VEC_LAST) begin
            state_s = ST_REPORT;
          end else begin
            vec_s   = vec_r + 16'd1;
            state_s = ST_DRIVE;
          end
        end
        ST_REPORT: begin
          if (res_ready_i) begin
            if (cand_r == CAND_LAST) begin
              state_s = ST_DONE;
            end else begin
              cand_s  = cand_r + 7'd1;
              vec_s   = 16'd0;
              err_s   = 16'd0;
              lfsr_s  = LFSR_SEED;
              state_s = ST_DRIVE;
            end
          end else begin
            state_s = ST_REPORT;
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      base_r  <= 64'd0;
      cand_r  <= 7'd0;
      vec_r   <= 16'd0;
      err_r   <= 16'd0;
      lfsr_r  <= LFSR_SEED;
      wait_r  <= 4'd0;
      op1_r   <= 8'd0;
      op2_r   <= 8'd0;
      key_r   <= 64'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      base_r  <= base_s;
      cand_r  <= cand_s;
      vec_r   <= vec_s;
      err_r   <= err_s;
      lfsr_r  <= lfsr_s;
      wait_r  <= wait_s;
      op1_r   <= op1_s;
      op2_r   <= op2_s;
      key_r   <= key_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      valid_r <= (state_s == ST_REPORT);
    end
  end

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign op1_o       = op1_r;
  assign op2_o       = op2_r;
  assign keyinput_o  = key_r;
  assign res_valid_o = valid_r;
  assign res_idx_o   = cand_r;
  assign res_err_o   = err_r;

endmodule

// File: tb/tb_locked_mult_key_sweep_ctrl.sv
// Directed bench for locked_mult_key_sweep_ctrl: a default-parameter instance
// and an NVEC=4 / SETTLE=0 instance, each wired to a behavioural locked multiplier.
module tb_locked_mult_key_sweep_ctrl;

  localparam logic [63:0] KEY_K   = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] SM_BASE = 64'h0123_4567_89AB_CDEF;

  logic        clk_s = 1'b0;
  logic        rst_n_s;

  // default-parameter instance
  logic        start_s, abort_s, ready_s, keyed_s;
  logic [63:0] base_s;
  logic        busy_s, done_s, valid_s;
  logic [7:0]  op1_s, op2_s;
  logic [63:0] key_s;
  logic [15:0] prod_s, err_s;
  logic [6:0]  idx_s;

  // NVEC=4, SETTLE=0 instance
  logic        sm_start_s, sm_abort_s, sm_ready_s;
  logic [63:0] sm_base_s;
  logic        sm_busy_s, sm_done_s, sm_valid_s;
  logic [7:0]  sm_op1_s, sm_op2_s;
  logic [63:0] sm_key_s;
  logic [15:0] sm_prod_s, sm_err_s;
  logic [6:0]  sm_idx_s;

  int n_checks = 0;
  int n_pass   = 0;

  int          got_n;
  logic [6:0]  got_idx [0:64];
  logic [15:0] got_err [0:64];
  int          lat;
  int          bp_bad;

  logic [15:0] exp_ops [0:3] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};

  always #5 clk_s = ~clk_s;

  // Behavioural locked multipliers: keyed mode corrupts bit 0 unless the key is K.
  assign prod_s    = (16'(op1_s) * 16'(op2_s)) ^ ((keyed_s && (key_s != KEY_K)) ? 16'h0001 : 16'h0000);
  assign sm_prod_s = 16'(sm_op1_s) * 16'(sm_op2_s);

  locked_mult_key_sweep_ctrl dut (
    .clk_i(clk_s), .rst_ni(rst_n_s), .start_i(start_s), .abort_i(abort_s),
    .key_base_i(base_s), .busy_o(busy_s), .done_o(done_s),
    .op1_o(op1_s), .op2_o(op2_s), .keyinput_o(key_s), .locked_prod_i(prod_s),
    .res_valid_o(valid_s), .res_ready_i(ready_s), .res_idx_o(idx_s), .res_err_o(err_s)
  );

  locked_mult_key_sweep_ctrl #(.NVEC(4), .SETTLE(0), .LFSR_SEED(16'hACE1)) dut_sm (
    .clk_i(clk_s), .rst_ni(rst_n_s), .start_i(sm_start_s), .abort_i(sm_abort_s),
    .key_base_i(sm_base_s), .busy_o(sm_busy_s), .done_o(sm_done_s),
    .op1_o(sm_op1_s), .op2_o(sm_op2_s), .keyinput_o(sm_key_s), .locked_prod_i(sm_prod_s),
    .res_valid_o(sm_valid_s), .res_ready_i(sm_ready_s), .res_idx_o(sm_idx_s), .res_err_o(sm_err_s)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  // Full sweep on the default instance; optional 10-cycle stall on one report,
  // a start pulse while busy, and optional abort alongside the initial start.
  task automatic run_sweep(input logic [63:0] base, input logic keyed, input int bp_idx,
                           input logic with_abort, input string tag);
    int         cyc;
    bit         bp_done;
    bit         seen_done;
    logic [6:0] hold_idx;
    logic [15:0] hold_err;
    keyed_s = keyed; base_s = base; got_n = 0; lat = 0; bp_bad = 0;
    bp_done = 1'b0; seen_done = 1'b0;
    start_s = 1'b1; abort_s = with_abort;
    tick();
    start_s = 1'b0; abort_s = 1'b0;
    check_eq({tag, " busy_after_start"}, 64'(busy_s), 64'd1);
    cyc = 0;
    while (!seen_done && cyc < 14000) begin
      start_s = (cyc == 3000);
      if (valid_s) begin
        if ((int'(idx_s) == bp_idx) && !bp_done) begin
          bp_done = 1'b1; ready_s = 1'b0; hold_idx = idx_s; hold_err = err_s;
          for (int i = 0; i < 10; i++) begin
            tick(); cyc++;
            if (!valid_s || idx_s != hold_idx || err_s != hold_err) bp_bad++;
          end
          ready_s = 1'b1;
        end
        if (got_n < 65) begin
          got_idx[got_n] = idx_s;
          got_err[got_n] = err_s;
        end
        got_n++;
      end
      if (done_s) begin
        seen_done = 1'b1;
        lat = cyc + 1;
      end
      tick(); cyc++;
    end
    start_s = 1'b0;
  endtask

  task automatic check_results(input string tag, input bit all_good, input int good_idx, input int exp_lat);
    check_eq({tag, " count"}, 64'(got_n), 64'd65);
    for (int i = 0; i < 65 && i < got_n; i++) begin
      check_eq($sformatf("%s idx[%0d]", tag, i), 64'(got_idx[i]), 64'(i));
      check_eq($sformatf("%s err[%0d]", tag, i), 64'(got_err[i]),
               (all_good || i == good_idx) ? 64'd0 : 64'd64);
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int cyc;
    int c;
    int r;
    int cnt;
    bit seen;
    logic [63:0] exp_key;

    rst_n_s = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; ready_s = 1'b1; keyed_s = 1'b0; base_s = 64'd0;
    sm_start_s = 1'b0; sm_abort_s = 1'b0; sm_ready_s = 1'b1; sm_base_s = SM_BASE;
    repeat (3) tick();

    // reset values
    check_eq("rst busy",  64'(busy_s),  64'd0);
    check_eq("rst done",  64'(done_s),  64'd0);
    check_eq("rst valid", 64'(valid_s), 64'd0);
    check_eq("rst idx",   64'(idx_s),   64'd0);
    check_eq("rst err",   64'(err_s),   64'd0);
    check_eq("rst ops",   64'({op1_s, op2_s}), 64'd0);
    check_eq("rst key",   key_s, 64'd0);
    rst_n_s = 1'b1;
    tick();
    check_eq("idle busy", 64'(busy_s), 64'd0);

    // NVEC=4, SETTLE=0: operand order, 2 cycles per vector, same for each candidate
    sm_start_s = 1'b1;
    tick();
    sm_start_s = 1'b0;
    seen = 1'b0; lat = 0;
    for (cyc = 0; cyc < 700 && !seen; cyc++) begin
      c = cyc / 9;
      r = cyc % 9;
      if (c < 65) begin
        if (r == 8) begin
          check_eq($sformatf("sm valid[%0d]", c), 64'(sm_valid_s), 64'd1);
          check_eq($sformatf("sm idx[%0d]", c), 64'(sm_idx_s), 64'(c));
          check_eq($sformatf("sm err[%0d]", c), 64'(sm_err_s), 64'd0);
        end else if ((r % 2) == 1) begin
          check_eq($sformatf("sm ops[%0d][%0d]", c, r / 2), 64'({sm_op1_s, sm_op2_s}), 64'(exp_ops[r / 2]));
          if (r == 1) begin
            exp_key = (c == 0) ? SM_BASE : (SM_BASE ^ (64'd1 << (c - 1)));
            check_eq($sformatf("sm key[%0d]", c), sm_key_s, exp_key);
          end
        end
      end
      if (sm_done_s) begin
        seen = 1'b1;
        lat = cyc + 1;
      end
      tick();
    end
    check_eq("sm latency", 64'(lat), 64'd586);

    // ideal model, base 0
    run_sweep(64'd0, 1'b0, -1, 1'b0, "ideal");
    check_results("ideal", 1'b1, -1, 12546);

    // keyed model, base = K, 10-cycle stall on idx 3
    run_sweep(KEY_K, 1'b1, 3, 1'b0, "keyK");
    check_results("keyK", 1'b0, 0, 12556);
    check_eq("bp stable", 64'(bp_bad), 64'd0);

    // keyed model, base = K^(1<<5); abort alongside start must lose
    run_sweep(KEY_K ^ (64'd1 << 5), 1'b1, -1, 1'b1, "keyK5");
    check_results("keyK5", 1'b0, 6, 12546);

    // abort in WAIT of candidate 7, second vector
    keyed_s = 1'b0; base_s = 64'd0;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cnt = 0;
    for (cyc = 0; cyc < 1355; cyc++) begin
      if (valid_s) cnt++;
      tick();
    end
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    check_eq("abort busy",  64'(busy_s),  64'd0);
    check_eq("abort valid", 64'(valid_s), 64'd0);
    check_eq("abort done",  64'(done_s),  64'd0);
    check_eq("abort results", 64'(cnt), 64'd7);
    check_eq("abort ops",   64'({op1_s, op2_s}), 64'h59C3);
    check_eq("abort key",   key_s, 64'h40);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_s || busy_s) cnt++;
    end
    check_eq("abort quiet", 64'(cnt), 64'd0);

    // restart after abort begins from candidate 0 and the seed
    base_s = 64'h5555_0000_AAAA_0001;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    tick();
    check_eq("restart ops", 64'({op1_s, op2_s}), 64'hACE1);
    check_eq("restart key", key_s, 64'h5555_0000_AAAA_0001);
    seen = 1'b0;
    for (cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (valid_s) seen = 1'b1;
      else tick();
    end
    check_eq("restart seen", 64'(seen), 64'd1);
    check_eq("restart idx", 64'(idx_s), 64'd0);

    // reset asserted while a result is offered
    ready_s = 1'b0;
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    keyed_s = 1'b1; base_s = KEY_K ^ 64'd1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 400 && !seen; cyc++) begin
      if (valid_s) seen = 1'b1;
      else tick();
    end
    check_eq("prerst seen", 64'(seen), 64'd1);
    check_eq("prerst err",  64'(err_s), 64'd64);
    rst_n_s = 1'b0;
    #1;
    check_eq("mrst busy",  64'(busy_s),  64'd0);
    check_eq("mrst done",  64'(done_s),  64'd0);
    check_eq("mrst valid", 64'(valid_s), 64'd0);
    check_eq("mrst idx",   64'(idx_s),   64'd0);
    check_eq("mrst err",   64'(err_s),   64'd0);
    check_eq("mrst ops",   64'({op1_s, op2_s}), 64'd0);
    check_eq("mrst key",   key_s, 64'd0);
    tick();
    rst_n_s = 1'b1;
    ready_s = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_s || done_s || busy_s) cnt++;
    end
    check_eq("mrst quiet", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/locked_mult_key_sweep_ctrl.md
# locked_mult_key_sweep_ctrl

Sequencer that drives the combinational XOR-locked 8x8 array multiplier through a partial-key sweep. Candidate 0 is a base key. Candidates 1..64 are the base key with exactly one key bit flipped. For each candidate the block applies the same pseudo-random operand set, compares the locked product against the true product, and reports a mismatch count per candidate over a valid/ready port. It sits between the bench or host harness and the locked multiplier instance, which is wired externally to op1_o / op2_o / keyinput_o / locked_prod_i.

## Interface
- NVEC, 64: operand vectors per key candidate; legal range 1..65535.
- SETTLE, 1: wait cycles between driving the multiplier and sampling it; legal range 0..15.
- LFSR_SEED, 16'hACE1: operand LFSR seed; must be nonzero.

- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  begin sweep; honoured only in IDLE.
- abort_i  in  1  cancel sweep; return to IDLE.
- key_base_i  in  64  base key; latched on an accepted start.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at the end of a completed sweep.
- op1_o  out  8  multiplicand to the locked multiplier; registered.
- op2_o  out  8  multiplier to the locked multiplier; registered.
- keyinput_o  out  64  candidate key to the locked multiplier; registered.
- locked_prod_i  in  16  product returned by the locked multiplier.
- res_valid_o  out  1  per-candidate result valid.
- res_ready_i  in  1  result accepted.
- res_idx_o  out  7  candidate index: 0 = base key, k = key bit k-1 flipped.
- res_err_o  out  16  mismatch count for that candidate (0..NVEC).

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, REPORT, DONE.
- IDLE, on start_i:
  - latch key_base_i; cand=0; vec=0; err=0; lfsr=LFSR_SEED.
  - go to DRIVE.
- DRIVE (1 cycle):
  - op1_o=lfsr[15:8]; op2_o=lfsr[7:0].
  - keyinput_o = base if cand==0, else base ^ (64'b1 << (cand-1)).
  - go to WAIT if SETTLE>0, else to CHECK.
- WAIT: count SETTLE cycles, then go to CHECK.
- CHECK (1 cycle):
  - golden = op1_o*op2_o, unsigned, 16 bits, no truncation.
  - if locked_prod_i != golden then err=err+1.
  - advance the LFSR: Fibonacci, taps 16,14,13,11; new bit0 = b15^b13^b12^b10; shift left.
  - if vec==NVEC-1, go to REPORT; else vec=vec+1 and go to DRIVE.
- REPORT:
  - res_valid_o=1, res_idx_o=cand, res_err_o=err (final count, including the last CHECK).
  - hold all three stable until res_ready_i=1.
  - on handshake: if cand==64 go to DONE; else cand=cand+1, vec=0, err=0, lfsr=LFSR_SEED, go to DRIVE.
  - every candidate therefore sees an identical operand sequence.
- DONE: done_o=1 for one cycle, then go to IDLE.
- abort_i takes priority in any non-IDLE state:
  - next state is IDLE; res_valid_o drops; no done_o pulse.
  - op/key outputs hold their last values.
  - a result offered in the same cycle as abort_i is not counted as delivered.
- start_i while busy is ignored. start_i and abort_i together in IDLE: start wins.
- The error counter cannot overflow, because NVEC <= 65535.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE.
  - all outputs 0: busy_o, done_o, res_valid_o, res_idx_o, res_err_o, op1_o, op2_o, keyinput_o.
  - lfsr=LFSR_SEED.
- Reset mid-sweep: immediate return to the reset values; no result or done is emitted.
- Start sampled at edge t: busy_o=1 from t+1; first DRIVE occupies t+1; the operands are visible at t+2.
- Per vector: 2+SETTLE cycles (DRIVE, SETTLE x WAIT, CHECK).
- locked_prod_i is sampled at the CHECK edge, SETTLE+1 cycles after the operands change.
- Per candidate, with res_ready_i held at 1: NVEC*(2+SETTLE)+1 cycles.
- Full sweep with ready held at 1: 65*(NVEC*(2+SETTLE)+1)+1 cycles from start to the done_o cycle. Defaults give 65*193+1 = 12546.
- Backpressure: each cycle of res_ready_i=0 adds one cycle. No vector work happens while in REPORT.
- res_valid_o may assert only in REPORT. It never drops without a handshake, except on abort or reset.

## Test plan
- Default parameters; ideal bench model (locked_prod_i = op1_o*op2_o for any key); base = 64'h0. Expect 65 results with idx 0..64, every res_err_o=0, and done_o exactly 12546 cycles after start.
- Model returns the correct product only when keyinput_o == K = 64'hDEAD_BEEF_0123_4567, else product ^ 16'h0001. Base=K gives idx0 err=0 and idx1..64 err=64 each. Base = K^(1<<5) gives idx6 err=0 and every other idx err=64.
- NVEC=4, SETTLE=0. Check that op1_o/op2_o per candidate are {AC,E1}, followed by the next three LFSR states, identical for every candidate. Check 2 cycles per vector.
- res_ready_i deasserted for 10 cycles during the idx 3 report: res_valid_o, res_idx_o=3 and res_err_o stay stable; the total latency grows by exactly 10.
- abort_i pulsed during WAIT of candidate 7: IDLE next cycle, busy_o=0, no done_o. A new start then restarts at idx 0 with lfsr=ACE1.
- rst_ni low during REPORT: all outputs 0 immediately. start_i while busy has no effect on the result sequence.
